hunter_frame_encoder: RTL and testbench

HUNTER_FRAME_ENCODER -- requirements
Module: hunter_frame_encoder

---
 rtl/hunter_pkg.sv | 22 ++
 rtl/phase_tick_gen.sv | 24 ++
 rtl/hunter_frame_encoder.sv | 133 +++++++++++++
 tb/tb_hunter_frame_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hunter_pkg.sv
// hunter_pkg: shared FSM states, command constants and cmd-to-payload mapping.
// Macro HUNTER_FRAME_REPEAT_EN adds the GAP state used between repeated frames.
package hunter_pkg;

   localparam logic [2:0] CMD_MAX      = 3'd4;
   localparam int         PAYLOAD_BITS = 7;

`ifdef HUNTER_FRAME_REPEAT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, GAP = 2'd2, FINISH = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, FINISH = 2'd3} state_t;
`endif

   function automatic logic [PAYLOAD_BITS-1:0] cmd_to_payload(input logic [2:0] c);
      return (c == 3'd0) ? 7'b1001111 :
             (c == 3'd1) ? 7'b1000111 :
             (c == 3'd2) ? 7'b0100111 :
             (c == 3'd3) ? 7'b0010111 :
             (c == 3'd4) ? 7'b0001111 : 7'b0000000;
   endfunction

endpackage

// File: rtl/phase_tick_gen.sv
// phase_tick_gen: one-cycle tick on the last cycle of every DIV-cycle phase, realigned by restart.
module phase_tick_gen #(
   parameter int DIV = 2048
) (
   input  logic ref_clk,
   input  logic reset_n,
   input  logic restart,
   output logic tick
);

   localparam int             CW   = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = (r_cnt == LAST);

   // free-running phase counter; restart puts the next cycle at the start of a phase
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) r_cnt <= '0;
      else          r_cnt <= (restart || tick) ? '0 : r_cnt + 1'b1;
   end

endmodule

// File: rtl/hunter_frame_encoder.sv
// hunter_frame_encoder: OOK frame encoder (0 / data / 1 phases per symbol).
// Macro HUNTER_FRAME_REPEAT_EN: send REPEATS frames separated by GAP_PHASES low phases;
// without it exactly one frame is sent and REPEATS/GAP_PHASES have no effect.
module hunter_frame_encoder
   import hunter_pkg::*;
#(
   parameter int DIV           = 2048,
   parameter int ID_WIDTH      = 4,
   parameter int PAYLOAD_WIDTH = 7,
   parameter int LEAD_SYMS     = 2,
   parameter int REPEATS       = 3,
   parameter int GAP_PHASES    = 30
) (
   input  logic                ref_clk,
   input  logic                reset_n,
   input  logic [ID_WIDTH-1:0] id,
   input  logic [2:0]          cmd,
   input  logic                start,
   input  logic                abort,
   output logic                out,
   output logic                busy,
   output logic                done,
   output logic                cmd_err
);

   localparam int             NSYM     = LEAD_SYMS + ID_WIDTH + PAYLOAD_WIDTH;
   localparam int             SW       = $clog2(NSYM + 1);
   localparam logic [SW-1:0] LAST_SYM = SW'(NSYM - 1);

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_ph;
   logic [SW-1:0]   r_sym;
   logic [NSYM-1:0] r_bits;
   logic            r_abort;
   logic            r_cmd_err;
   logic            w_tick, w_accept, w_abort_req, w_frame_end;
   logic [NSYM-1:0] w_frame_in;

   assign w_frame_in  = {PAYLOAD_WIDTH'(cmd_to_payload(cmd)), id, {LEAD_SYMS{1'b0}}};
   assign w_accept    = (r_state == IDLE) && start && (cmd <= CMD_MAX);
   assign w_abort_req = abort || r_abort;
   assign w_frame_end = w_tick && (r_ph == 2'd2) && (r_sym == LAST_SYM);
   assign cmd_err     = r_cmd_err;

   phase_tick_gen #(.DIV(DIV)) u_tick (
      .ref_clk (ref_clk),
      .reset_n (reset_n),
      .restart (w_accept),
      .tick    (w_tick)
   );

`ifdef HUNTER_FRAME_REPEAT_EN
   localparam int             FW       = $clog2(REPEATS + 1);
   localparam int             GW       = $clog2(GAP_PHASES + 1);
   localparam logic [FW-1:0] LAST_FRM = FW'(REPEATS - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_PHASES - 1);

   logic [FW-1:0]   r_frm;
   logic [GW-1:0]   r_gap;
   logic [NSYM-1:0] r_frame;

   // count completed frames and gap phases; r_frame reloads the shifter for each repeat
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frm   <= '0;
         r_gap   <= '0;
         r_frame <= '0;
      end else begin
         if (w_accept) r_frame <= w_frame_in;
         r_frm <= (r_state == IDLE) ? '0 :
                  (r_state == FRAME && w_frame_end && !w_abort_req && r_frm != LAST_FRM) ? r_frm + 1'b1 : r_frm;
         r_gap <= (r_state != GAP) ? '0 : w_tick ? r_gap + 1'b1 : r_gap;
      end
   end
`else
   logic [31:0] w_cfg_unused;
   assign w_cfg_unused = REPEATS ^ GAP_PHASES;
`endif

   // state register
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // next state and line outputs; abort only takes effect on a phase boundary
   always_comb begin
      w_state_nxt = r_state;
      out         = 1'b0;
      busy        = (r_state != IDLE);
      done        = (r_state == FINISH);
      if (r_state == FRAME) out = (r_ph == 2'd2) | ((r_ph == 2'd1) & r_bits[0]);
      case (r_state)
         IDLE:    w_state_nxt = w_accept ? FRAME : IDLE;
`ifdef HUNTER_FRAME_REPEAT_EN
         FRAME:   w_state_nxt = (w_tick && w_abort_req) ? FINISH :
                                w_frame_end ? ((r_frm == LAST_FRM) ? FINISH : GAP) : FRAME;
         GAP:     w_state_nxt = !w_tick ? GAP : w_abort_req ? FINISH : (r_gap == LAST_GAP) ? FRAME : GAP;
`else
         FRAME:   w_state_nxt = ((w_tick && w_abort_req) || w_frame_end) ? FINISH : FRAME;
`endif
         FINISH:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // phase/symbol counters, data shifter, pending abort and invalid-command pulse
   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ph      <= '0;
         r_sym     <= '0;
         r_bits    <= '0;
         r_abort   <= 1'b0;
         r_cmd_err <= 1'b0;
      end else begin
         r_cmd_err <= (r_state == IDLE) && start && (cmd > CMD_MAX);
         r_abort   <= (r_state != IDLE) && (r_state != FINISH) && !w_tick && w_abort_req;
         if (r_state == FRAME && w_tick) begin
            r_ph <= (r_ph == 2'd2) ? 2'd0 : r_ph + 1'b1;
            if (r_ph == 2'd2) r_sym <= (r_sym == LAST_SYM) ? '0 : r_sym + 1'b1;
         end else if (r_state != FRAME) begin
            r_ph  <= '0;
            r_sym <= '0;
         end
         if (w_accept) r_bits <= w_frame_in;
         else if (r_state == FRAME && w_tick && r_ph == 2'd2) r_bits <= r_bits >> 1;
`ifdef HUNTER_FRAME_REPEAT_EN
         else if (r_state == GAP) r_bits <= r_frame;
`endif
      end
   end

endmodule

// File: tb/tb_hunter_frame_encoder.sv
// tb_hunter_frame_encoder: waveform-model checker plus directed scenarios for hunter_frame_encoder.
module tb_hunter_frame_encoder;

   localparam int DIV     = 4;
   localparam int FLEN    = 156;
   localparam int GAPC    = 8;
   localparam int FSTRIDE = 164;
`ifdef HUNTER_FRAME_REPEAT_EN
   localparam int NFR   = 3;
   localparam int L_EXP = 484;
`else
   localparam int NFR   = 1;
   localparam int L_EXP = 156;
`endif

   logic       ref_clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] id      = '0;
   logic [2:0] cmd     = '0;
   logic       start   = 1'b0;
   logic       abort   = 1'b0;
   logic       out, busy, done, cmd_err;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 ref_clk = ~ref_clk;

   hunter_frame_encoder #(
      .DIV(DIV), .ID_WIDTH(4), .PAYLOAD_WIDTH(7), .LEAD_SYMS(2), .REPEATS(3), .GAP_PHASES(2)
   ) dut (
      .ref_clk (ref_clk),
      .reset_n (reset_n),
      .id      (id),
      .cmd     (cmd),
      .start   (start),
      .abort   (abort),
      .out     (out),
      .busy    (busy),
      .done    (done),
      .cmd_err (cmd_err)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   // Model: a request is the full expected line waveform; the cycle after it is the done cycle.
   logic       m_seq[$];
   int         m_k = 0;
   int         m_len = 0;
   bit         m_active = 0, m_pend = 0, m_err = 0;
   logic [6:0] pay_tab [0:4] = '{7'b1001111, 7'b1000111, 7'b0100111, 7'b0010111, 7'b0001111};

   function automatic void build(input logic [3:0] i, input logic [2:0] c);
      logic d[$];
      m_seq.delete();
      d.push_back(1'b0);
      d.push_back(1'b0);
      for (int b = 0; b < 4; b++) d.push_back(i[b]);
      for (int b = 0; b < 7; b++) d.push_back(pay_tab[c][b]);
      for (int f = 0; f < NFR; f++) begin
         if (f > 0) repeat (GAPC) m_seq.push_back(1'b0);
         foreach (d[s]) begin
            repeat (DIV) m_seq.push_back(1'b0);
            repeat (DIV) m_seq.push_back(d[s]);
            repeat (DIV) m_seq.push_back(1'b1);
         end
      end
      m_len = m_seq.size();
   endfunction

   always @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         m_active <= 0;
         m_pend   <= 0;
         m_err    <= 0;
         m_k      <= 0;
      end else begin
         m_err <= 0;
         if (m_active) begin
            if (m_k == m_len) begin
               m_active <= 0;
               m_pend   <= 0;
            end else if ((m_pend || abort) && (m_k % DIV == DIV - 1)) begin
               m_k    <= m_len;
               m_pend <= 0;
            end else begin
               m_k    <= m_k + 1;
               m_pend <= m_pend || abort;
            end
         end else if (start) begin
            if (cmd > 3'd4) m_err <= 1;
            else begin
               build(id, cmd);
               m_k      <= 0;
               m_pend   <= 0;
               m_active <= 1;
            end
         end
      end
   end

   // every-cycle comparison of {out,busy,done,cmd_err} against the model
   always @(posedge ref_clk) begin
      logic eo, eb, ed, ee;
      #1;
      eo = (m_active && m_k < m_len) ? m_seq[m_k] : 1'b0;
      eb = m_active;
      ed = m_active && (m_k == m_len);
      ee = m_err;
      chk($sformatf("model t=%0t {out,busy,done,cmd_err}", $time), {out, busy, done, cmd_err}, {eo, eb, ed, ee});
   end

   task automatic step();
      @(posedge ref_clk);
      #1;
   endtask

   task automatic run_frame(input logic [3:0] i, input logic [2:0] c, input logic [12:0] vec,
                            input bit inj, input bit ab, input string name);
      logic ro [0:511];
      logic rb [0:511];
      logic rd [0:511];
      int dn, dk, bh, base;
      logic [12:0] got;
      logic z, o, g;
      @(negedge ref_clk);
      id = i; cmd = c; start = 1'b1; abort = ab;
      step();
      start = 1'b0; abort = 1'b0;
      for (int k = 0; k < L_EXP + 3; k++) begin
         ro[k] = out; rb[k] = busy; rd[k] = done;
         if (inj && k == 40) begin id = 4'b1111; cmd = 3'd2; start = 1'b1; end
         if (inj && k == 41) start = 1'b0;
         step();
      end
      dn = 0; dk = -1; bh = 0;
      for (int k = 0; k < L_EXP + 3; k++) begin
         if (rd[k]) begin dn++; if (dk < 0) dk = k; end
         if (rb[k]) bh++;
      end
      chk({name, " done pulses"}, dn, 1);
      chk({name, " done cycle"}, dk, L_EXP);
      chk({name, " busy cycles"}, bh, L_EXP + 1);
      chk({name, " busy low after done"}, int'(rb[L_EXP + 1]), 0);
      for (int f = 0; f < NFR; f++) begin
         base = f * FSTRIDE;
         z = 1'b0; o = 1'b1;
         for (int s = 0; s < 13; s++) begin
            got[s] = ro[base + 12 * s + 4];
            for (int p = 0; p < DIV; p++) begin
               z = z | ro[base + 12 * s + p];
               o = o & ro[base + 12 * s + 8 + p];
            end
         end
         chk($sformatf("%s frame%0d data bits", name, f), int'(got), int'(vec));
         chk($sformatf("%s frame%0d first phases low", name, f), int'(z), 0);
         chk($sformatf("%s frame%0d last phases high", name, f), int'(o), 1);
         if (f < NFR - 1) begin
            g = 1'b0;
            for (int k = 0; k < GAPC; k++) g = g | ro[base + FLEN + k];
            chk($sformatf("%s gap%0d low", name, f), int'(g), 0);
         end
      end
   endtask

   initial begin
      int dn;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge ref_clk);
      chk("reset outputs", {out, busy, done, cmd_err}, 0);
      reset_n = 1'b1;
      @(posedge ref_clk);

      run_frame(4'b1010, 3'd0, {7'b1001111, 4'b1010, 2'b00}, 0, 0, "single");

      @(negedge ref_clk);
      id = 4'b0011; cmd = 3'd6; start = 1'b1;
      step();
      start = 1'b0;
      chk("bad cmd cmd_err", cmd_err, 1);
      chk("bad cmd busy", busy, 0);
      step();
      chk("bad cmd cmd_err drop", cmd_err, 0);
      chk("bad cmd busy/out", {busy, out}, 0);

      run_frame(4'b0101, 3'd0, {7'b1001111, 4'b0101, 2'b00}, 1, 0, "start_busy");
      repeat (5) step();
      chk("no queued request", busy, 0);

      @(negedge ref_clk);
      id = 4'b0001; cmd = 3'd0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (30) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort c31 out", out, 1);
      chk("abort c31 busy/done", {busy, done}, 2);
      step();
      chk("abort c32 out", out, 0);
      chk("abort c32 busy/done", {busy, done}, 3);
      step();
      chk("abort c33 busy/done", {busy, done}, 0);
      repeat (2) step();

      run_frame(4'b0011, 3'd4, {7'b0001111, 4'b0011, 2'b00}, 0, 1, "abort_start_idle");
      run_frame(4'b1001, 3'd2, {7'b0100111, 4'b1001, 2'b00}, 0, 0, "cmd2");

      @(negedge ref_clk);
      id = 4'b1010; cmd = 3'd1; start = 1'b1;
      step();
      start = 1'b0;
      dn = 0;
      for (int k = 0; k < 50; k++) begin dn += int'(done); step(); end
      @(negedge ref_clk);
      reset_n = 1'b0;
      #1;
      chk("reset mid-frame outputs", {out, busy, done}, 0);
      repeat (3) begin @(negedge ref_clk); dn += int'(done); end
      chk("reset mid-frame no done", dn, 0);
      reset_n = 1'b1;
      @(posedge ref_clk);
      run_frame(4'b1100, 3'd3, {7'b0010111, 4'b1100, 2'b00}, 0, 0, "after_reset");
      run_frame(4'b0110, 3'd1, {7'b1000111, 4'b0110, 2'b00}, 0, 0, "cmd1");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
